// File: rtl/oflow_prev_feature_feeder.sv
// Previous-frame feature feeder for the similarity metric PE.
// Holds a line buffer loaded by the frame loader. On go, the buffer is swept line by line.
// Each line is presented to the PE with a one-cycle pe_start pulse. The next line is
// prefetched into a staging register when the PE asks for it, and becomes current on pe_valid.
module oflow_prev_feature_feeder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   num_lines,
  input  logic              go,
  input  logic              pe_control_for_read_new_line,
  input  logic              pe_valid,
  output logic              pe_start,
  output logic [DATA_W-1:0] features_of_prev,
  output logic [ADDR_W-1:0] line_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StFinish} state_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] staging_q;
  logic              staged_q;
  logic [ADDR_W:0]   n_q;
  state_e            state_q;

  logic [ADDR_W:0]   go_n;
  logic [ADDR_W:0]   next_idx;
  logic              has_next;

  // Clamp the requested line count and work out whether another line follows the current one.
  always_comb begin
    go_n     = (num_lines > (ADDR_W + 1)'(DEPTH)) ? (ADDR_W + 1)'(DEPTH) : num_lines;
    next_idx = {1'b0, line_idx} + (ADDR_W + 1)'(1);
    has_next = next_idx < n_q;
  end

  // Loader writes; the buffer is frozen while a sweep is reading it.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q          <= StIdle;
      pe_start         <= 1'b0;
      features_of_prev <= '0;
      line_idx         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      staging_q        <= '0;
      staged_q         <= 1'b0;
      n_q              <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pe_start <= 1'b0;
          done     <= 1'b0;
          if (go) begin
            if (go_n != '0) begin
              n_q              <= go_n;
              features_of_prev <= mem[0];
              line_idx         <= '0;
              staged_q         <= 1'b0;
              pe_start         <= 1'b1;
              busy             <= 1'b1;
              state_q          <= StIssue;
            end else begin
              // Empty sweep: report completion without touching the PE.
              done <= 1'b1;
            end
          end
        end
        StIssue: begin
          pe_start <= 1'b0;
          state_q  <= StRun;
        end
        StRun: begin
          if (pe_valid) begin
            staged_q <= 1'b0;
            if (has_next) begin
              // A prefetch request in the same cycle is dropped; read the buffer directly.
              if (staged_q && !pe_control_for_read_new_line) begin
                features_of_prev <= staging_q;
              end else begin
                features_of_prev <= mem[next_idx[ADDR_W-1:0]];
              end
              line_idx <= next_idx[ADDR_W-1:0];
              pe_start <= 1'b1;
              state_q  <= StIssue;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StFinish;
            end
          end else if (pe_control_for_read_new_line && has_next) begin
            staging_q <= mem[next_idx[ADDR_W-1:0]];
            staged_q  <= 1'b1;
          end
        end
        StFinish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_prev_feature_feeder.sv
// Directed bench for oflow_prev_feature_feeder with a simple PE handshake model.
module tb_oflow_prev_feature_feeder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_N;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   num_lines;
  logic              go;
  logic              pe_ctrl;
  logic              pe_valid;
  logic              pe_start;
  logic [DATA_W-1:0] features_of_prev;
  logic [ADDR_W-1:0] line_idx;
  logic              busy;
  logic              done;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] exp_mem [DEPTH];

  oflow_prev_feature_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk                          (clk),
    .reset_N                      (reset_N),
    .wr_en                        (wr_en),
    .wr_addr                      (wr_addr),
    .wr_data                      (wr_data),
    .num_lines                    (num_lines),
    .go                           (go),
    .pe_control_for_read_new_line (pe_ctrl),
    .pe_valid                     (pe_valid),
    .pe_start                     (pe_start),
    .features_of_prev             (features_of_prev),
    .line_idx                     (line_idx),
    .busy                         (busy),
    .done                         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse go and check the first line appears one cycle later.
  task automatic start_sweep(input int nl, input int n);
    num_lines = (ADDR_W + 1)'(nl);
    go = 1'b1;
    tick();
    go = 1'b0;
    if (n > 0) begin
      check("first_start", pe_start, 1);
      check("first_idx", line_idx, 0);
      check("first_line", features_of_prev, exp_mem[0]);
      check("first_busy", busy, 1);
      check("first_done", done, 0);
    end
  endtask

  // PE model for one line. mode 0: ctrl at +3, valid at +5; mode 1: valid only;
  // mode 2: ctrl and valid together at +5.
  task automatic run_line(input int k, input int n, input int mode);
    for (int j = 1; j <= 5; j++) begin
      tick();
      wr_en = 1'b0;
      check("start_low", pe_start, 0);
      check("line_hold", features_of_prev, exp_mem[k]);
      check("busy_run", busy, 1);
      pe_ctrl  = ((mode == 0) && (j == 3)) || ((mode == 2) && (j == 5));
      pe_valid = (j == 5);
    end
    tick();
    pe_ctrl  = 1'b0;
    pe_valid = 1'b0;
    if (k + 1 < n) begin
      check("next_start", pe_start, 1);
      check("next_idx", line_idx, 64'(k + 1));
      check("next_line", features_of_prev, exp_mem[k + 1]);
      check("next_done", done, 0);
    end else begin
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_start", pe_start, 0);
      check("end_line", features_of_prev, exp_mem[k]);
      check("end_idx", line_idx, 64'(k));
    end
  endtask

  task automatic sweep(input int nl, input int n, input int mode);
    start_sweep(nl, n);
    for (int k = 0; k < n; k++) run_line(k, n, mode);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_start", pe_start, 0);
  endtask

  initial begin
    reset_N   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    num_lines = '0;
    go        = 1'b0;
    pe_ctrl   = 1'b0;
    pe_valid  = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = 32'hC0DE_0000 | 32'(i + 32);
    exp_mem[0] = 32'hC0DE_0005;
    exp_mem[1] = 32'hC0DE_0009;
    exp_mem[2] = 32'hC0DE_000C;

    tick();
    tick();
    check("rst_start", pe_start, 0);
    check("rst_line", features_of_prev, 0);
    check("rst_idx", line_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_N = 1'b1;

    // Load the buffer while idle.
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = exp_mem[i];
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Three lines with prefetch.
    sweep(3, 3, 0);

    // PE activity while idle must not start anything.
    pe_valid = 1'b1;
    pe_ctrl  = 1'b1;
    tick();
    pe_valid = 1'b0;
    pe_ctrl  = 1'b0;
    tick();
    check("idle_pe_start", pe_start, 0);
    check("idle_pe_busy", busy, 0);

    // Empty sweep.
    start_sweep(0, 0);
    check("zero_done", done, 1);
    check("zero_start", pe_start, 0);
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_drop", done, 0);
    check("zero_start2", pe_start, 0);
    check("zero_busy2", busy, 0);

    // Over-length request clamps to the buffer depth.
    sweep(40, 32, 0);

    // No prefetch: fallback reads only.
    sweep(3, 3, 1);

    // Prefetch request coinciding with valid.
    sweep(3, 3, 2);

    // Write while busy is ignored; reset mid-sweep returns to idle without done.
    start_sweep(3, 3);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(1);
    wr_data = 32'hDEAD_BEEF;
    run_line(0, 3, 0);
    reset_N = 1'b0;
    #2;
    check("arst_start", pe_start, 0);
    check("arst_line", features_of_prev, 0);
    check("arst_idx", line_idx, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_done", done, 0);
    end
    reset_N = 1'b1;
    tick();
    sweep(3, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/oflow_prev_feature_feeder.md
Name: oflow_prev_feature_feeder

Overview:
- Producer side of the previous-frame feature interface of the similarity metric PE.
- Holds a local buffer of previous-frame feature lines, written by the frame loader.
- On `go`, streams each line to the PE on `features_of_prev` and pulses `pe_start` once per line.
- Prefetches the next line when the PE raises `control_for_read_new_line`; advances to it when the PE raises `valid`.

Parameters:
- DATA_W, default `DATA_TO_PE_WIDTH` (from oflow_core_define), width of one feature line including the ID in [`ID_LEN-1:0]
- DEPTH, default 32, number of buffer lines
- ADDR_W, default 5, address width, equal to clog2(DEPTH)

Ports:
- clk  in  1  clock
- reset_N  in  1  asynchronous active-low reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  buffer write address
- wr_data  in  DATA_W  buffer write data
- num_lines  in  ADDR_W+1  number of valid lines for the sweep, sampled on go
- go  in  1  one-cycle sweep start
- pe_control_for_read_new_line  in  1  PE prefetch request
- pe_valid  in  1  PE score valid, marks end of one line
- pe_start  out  1  one-cycle start to the PE
- features_of_prev  out  DATA_W  line presented to the PE
- line_idx  out  ADDR_W  index of the line currently presented
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset values:
  - pe_start=0, features_of_prev=0, line_idx=0, busy=0, done=0, FSM=IDLE.
  - Staging register, staged flag and line counters are cleared.
  - Buffer storage is not reset.
- Buffer:
  - Synchronous write: wr_en=1 and busy=0 writes wr_data to mem[wr_addr] at the clock edge.
  - wr_en while busy=1 is ignored and the memory is unchanged.
- All outputs are registered.
- num_lines is clamped to DEPTH when latched (N = min(num_lines, DEPTH)).
- FSM states: IDLE, ISSUE, RUN, FINISH.
- IDLE:
  - go=1 with N>0: latch N. Next cycle: features_of_prev=mem[0], line_idx=0, pe_start=1, busy=1. Go to ISSUE.
  - go=1 with N=0: done=1 for one cycle next cycle; pe_start stays 0; remain in IDLE.
- ISSUE: one cycle; pe_start drops to 0. Go to RUN.
- RUN, prefetch:
  - On pe_control_for_read_new_line=1 with line_idx+1<N: staging<=mem[line_idx+1], staged=1.
  - features_of_prev is held stable and unchanged until pe_valid.
- RUN, on pe_valid=1:
  - If line_idx+1<N: features_of_prev<=staging if staged=1, else mem[line_idx+1] (fallback, no prefetch seen). Also line_idx++, staged<=0, pe_start=1 in the following cycle. Go to ISSUE.
  - Else go to FINISH.
- FINISH: done=1 and busy=0 in the same cycle; features_of_prev holds the last line. Go to IDLE.
- Latency:
  - go to first pe_start: 1 cycle.
  - pe_valid to next pe_start: 1 cycle, matching PE idle-state start acceptance.
- Simultaneous control_for_read_new_line and pe_valid: pe_valid wins and the fallback direct buffer read is used; staged is cleared.
- pe_valid or control_for_read_new_line in IDLE or FINISH: ignored.
- go while busy=1: ignored.
- Reset mid-sweep: immediate return to IDLE with all outputs at reset values. No done pulse. Buffer contents are retained.
- line_idx never wraps; a sweep ends at N-1.

Test Plan:
- Load mem[0..2] = lines with IDs 5, 9, 12; go with num_lines=3; model PE raises control at +3 cycles and valid at +5 cycles after each start -> three pe_start pulses, each 1 cycle after the previous pe_valid; features_of_prev IDs 5, 9, 12 in order; stable between start and valid; done one cycle after the third pe_valid.
- go with num_lines=0 -> done pulse 1 cycle later, no pe_start, busy stays 0.
- num_lines=40 with DEPTH=32 -> exactly 32 pe_start pulses, line_idx ends at 31.
- PE never raises control; valid only -> fallback path presents mem[line_idx+1] correctly; same sequence as the first scenario.
- control_for_read_new_line and pe_valid in the same cycle -> next line correct, one pe_start pulse, no duplicate.
- Write to mem[1] while busy=1 -> ignored, line 1 unchanged. Assert reset_N low after the second pe_start -> all outputs 0 asynchronously, no done; a new go after release restarts at line 0 with the original buffer contents.
